// File: rtl/execute_stage_pipe.sv
// Registered execute stage: single-cycle ALU and branch resolution, iterative
// shift-add MUL and restoring DIVU, valid/ready on both the ID/EX and EX/MEM sides.
module execute_stage_pipe #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             src_imm,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             br_en,
  input  logic [1:0]       br_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             br_taken,
  output logic [WIDTH-1:0] pc_target,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             is_div_q, is_div_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             br_taken_q, br_taken_d;
  logic [WIDTH-1:0] pc_target_q, pc_target_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] b_s;
  logic [SW-1:0]    shamt_s;
  logic [SW:0]      rsh_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_v_s, alu_c_s, alu_err_s;
  logic             br_cond_s, start_multi_s, accept_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   rem_sh_s, diff_s;
  logic [WIDTH-1:0] fin_s;

  assign b_s       = src_imm ? imm : rd2;
  assign shamt_s   = b_s[SW-1:0];
  assign rsh_s     = (SW+1)'(WIDTH) - {1'b0, shamt_s};
  assign add_s     = {1'b0, rd1} + {1'b0, b_s};
  assign sub_s     = {1'b0, rd1} + {1'b0, ~b_s} + {{WIDTH{1'b0}}, 1'b1};
  assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign start_multi_s = !br_en &&
                         (((op == 4'd12) && MUL_EN) ||
                          ((op == 4'd13) && DIV_EN && (b_s != {WIDTH{1'b0}})));

  // One iteration of each multi-cycle unit; restoring divide keeps remainder in acc.
  assign mul_acc_s = acc_q + (opb_q[0] ? opa_q : {WIDTH{1'b0}});
  assign rem_sh_s  = {acc_q, opa_q[WIDTH-1]};
  assign diff_s    = rem_sh_s - {1'b0, opb_q};
  assign fin_s     = is_div_q ? opa_q : acc_q;

  // Single-cycle ALU result, overflow/carry and error.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_v_s   = 1'b0;
    alu_c_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      4'd0: begin
        alu_res_s = add_s[WIDTH-1:0];
        alu_c_s   = add_s[WIDTH];
        alu_v_s   = (rd1[WIDTH-1] == b_s[WIDTH-1]) && (add_s[WIDTH-1] != rd1[WIDTH-1]);
      end
      4'd1: begin
        alu_res_s = sub_s[WIDTH-1:0];
        alu_c_s   = sub_s[WIDTH];
        alu_v_s   = (rd1[WIDTH-1] != b_s[WIDTH-1]) && (sub_s[WIDTH-1] != rd1[WIDTH-1]);
      end
      4'd2:  alu_res_s = rd1 & b_s;
      4'd3:  alu_res_s = rd1 | b_s;
      4'd4:  alu_res_s = rd1 ^ b_s;
      4'd5:  alu_res_s = rd1 & ~b_s;
      4'd6:  alu_res_s = rd1 << shamt_s;
      4'd7:  alu_res_s = rd1 >> shamt_s;
      4'd8:  alu_res_s = $signed(rd1) >>> shamt_s;
      4'd9:  alu_res_s = (rd1 << shamt_s) | (rd1 >> rsh_s);
      4'd10: alu_res_s = b_s;
      4'd11: alu_res_s = (rd1 << HW) | {{HW{1'b0}}, b_s[HW-1:0]};
      4'd12: begin
        if (MUL_EN) begin
          alu_err_s = 1'b0;
        end else begin
          alu_err_s = 1'b1;
        end
      end
      4'd13: begin
        if (!DIV_EN) begin
          alu_err_s = 1'b1;
        end else if (b_s == {WIDTH{1'b0}}) begin
          alu_res_s = {WIDTH{1'b1}};
          alu_err_s = 1'b1;
        end else begin
          alu_err_s = 1'b0;
        end
      end
      default: alu_err_s = 1'b1;
    endcase
  end

  // Branch condition evaluated on rd1.
  always_comb begin
    case (br_type)
      2'd0:    br_cond_s = (rd1 == {WIDTH{1'b0}});
      2'd1:    br_cond_s = (rd1 != {WIDTH{1'b0}});
      2'd2:    br_cond_s = rd1[WIDTH-1];
      2'd3:    br_cond_s = !rd1[WIDTH-1];
      default: br_cond_s = 1'b0;
    endcase
  end

  // Sequencer next state and output register load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    pc_d        = pc_q;
    is_div_d    = is_div_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    flags_d     = flags_q;
    br_taken_d  = br_taken_q;
    pc_target_d = pc_target_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (br_en) begin
          out_valid_d = 1'b1;
          result_d    = pc_next;
          flags_d     = {rd1[WIDTH-1], (rd1 == {WIDTH{1'b0}}), 2'b00};
          br_taken_d  = br_cond_s;
          pc_target_d = br_cond_s ? (pc_next + imm) : pc_next;
          err_d       = 1'b0;
        end else if (start_multi_s) begin
          state_d  = ST_BUSY;
          cnt_d    = SW'(WIDTH - 1);
          is_div_d = (op == 4'd13);
          acc_d    = {WIDTH{1'b0}};
          opa_d    = rd1;
          opb_d    = b_s;
          pc_d     = pc_next;
        end else begin
          out_valid_d = 1'b1;
          result_d    = alu_res_s;
          flags_d     = {alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}}), alu_v_s, alu_c_s};
          br_taken_d  = 1'b0;
          pc_target_d = pc_next;
          err_d       = alu_err_s;
        end
      end
      ST_BUSY: begin
        if (is_div_q) begin
          if (!diff_s[WIDTH]) begin
            acc_d = diff_s[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh_s[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_acc_s;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
        if (cnt_q == {SW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      ST_DONE: begin
        if (!out_valid_q || out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = fin_s;
          flags_d     = {fin_s[WIDTH-1], (fin_s == {WIDTH{1'b0}}), 2'b00};
          br_taken_d  = 1'b0;
          pc_target_d = pc_q;
          err_d       = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = {SW{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State, iteration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {SW{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      opa_q       <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      pc_q        <= {WIDTH{1'b0}};
      is_div_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      br_taken_q  <= 1'b0;
      pc_target_q <= {WIDTH{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      pc_q        <= pc_d;
      is_div_q    <= is_div_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      br_taken_q  <= br_taken_d;
      pc_target_q <= pc_target_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign br_taken  = br_taken_q;
  assign pc_target = pc_target_q;
  assign err       = err_q;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed bench for execute_stage_pipe: ALU/branch vector table plus sequences
// for reset, multi-cycle latency, backpressure, flush and a 32-bit instance.
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready, src_imm, br_en;
  logic [3:0]  op;
  logic [1:0]  br_type;
  logic [15:0] rd1, rd2, imm, pc_next;
  logic        in_ready, out_valid, br_taken, err;
  logic [15:0] result, pc_target;
  logic [3:0]  flags;

  logic        d_in_ready, d_out_valid, d_br_taken, d_err;
  logic [15:0] d_result, d_pc_target;
  logic [3:0]  d_flags;

  logic        in_valid32, w_in_ready, w_out_valid, w_br_taken, w_err;
  logic [31:0] rd1_32, rd2_32, w_result, w_pc_target;
  logic [3:0]  w_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage_pipe #(.WIDTH(16), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_imm(src_imm), .rd1(rd1), .rd2(rd2), .imm(imm), .pc_next(pc_next),
    .br_en(br_en), .br_type(br_type), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .br_taken(br_taken), .pc_target(pc_target), .err(err));

  execute_stage_pipe #(.WIDTH(16), .MUL_EN(1'b0), .DIV_EN(1'b0)) dut_dis (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
    .op(op), .src_imm(src_imm), .rd1(rd1), .rd2(rd2), .imm(imm), .pc_next(pc_next),
    .br_en(br_en), .br_type(br_type), .out_valid(d_out_valid), .out_ready(out_ready),
    .result(d_result), .flags(d_flags), .br_taken(d_br_taken), .pc_target(d_pc_target),
    .err(d_err));

  execute_stage_pipe #(.WIDTH(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid32), .in_ready(w_in_ready),
    .op(op), .src_imm(1'b0), .rd1(rd1_32), .rd2(rd2_32), .imm(32'h0000_0000),
    .pc_next(32'h0000_0000), .br_en(1'b0), .br_type(2'd0), .out_valid(w_out_valid),
    .out_ready(out_ready), .result(w_result), .flags(w_flags), .br_taken(w_br_taken),
    .pc_target(w_pc_target), .err(w_err));

  typedef struct {
    logic [3:0]  op;
    logic        src_imm;
    logic [15:0] rd1, rd2, imm, pc_next;
    logic        br_en;
    logic [1:0]  br_type;
    logic [15:0] e_res;
    logic [3:0]  e_flags;
    logic        e_tk;
    logic [15:0] e_pct;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] o, input logic si, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] im, input logic [15:0] pc,
                         input logic be, input logic [1:0] bt, input logic [15:0] er,
                         input logic [3:0] ef, input logic et, input logic [15:0] ep,
                         input logic ee);
    vec_t v;
    v.op = o; v.src_imm = si; v.rd1 = a; v.rd2 = b; v.imm = im; v.pc_next = pc;
    v.br_en = be; v.br_type = bt; v.e_res = er; v.e_flags = ef; v.e_tk = et;
    v.e_pct = ep; v.e_err = ee;
    vq.push_back(v);
  endtask

  task automatic drive_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o; src_imm = 1'b0; rd1 = a; rd2 = b; imm = 16'h0000; pc_next = 16'h0000;
    br_en = 1'b0; br_type = 2'd0; in_valid = 1'b1;
  endtask

  // Counts edges from the accept edge until out_valid, flagging any in_ready seen.
  task automatic wait_out(input bit wide, input int exp_lat, input string nm);
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (!(wide ? w_out_valid : out_valid) && n < 100) begin
      if (wide ? w_in_ready : in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " in_ready low while busy"}, {31'd0, rdy_seen}, 32'd0);
  endtask

  task automatic watch_idle(input int cyc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({nm, " no stray out_valid"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid32 = 1'b0;
    rd1_32 = 32'd0; rd2_32 = 32'd0;
    drive_op(4'd0, 16'h0001, 16'h0002);

    // ALU vectors: op, src_imm, rd1, rd2, imm, pc_next, br_en, br_type, result, {N,Z,V,C}, taken, pc_target, err
    add_vec(4'd0,  0, 16'h7FFF, 16'h0001, 16'h0000, 16'h00AA, 0, 2'd0, 16'h8000, 4'b1010, 0, 16'h00AA, 0);
    add_vec(4'd0,  0, 16'hFFFF, 16'h0001, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0000, 4'b0101, 0, 16'h00AA, 0);
    add_vec(4'd1,  0, 16'h0005, 16'h0005, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0000, 4'b0101, 0, 16'h00AA, 0);
    add_vec(4'd1,  1, 16'h0003, 16'h1111, 16'h0005, 16'h00AA, 0, 2'd0, 16'hFFFE, 4'b1000, 0, 16'h00AA, 0);
    add_vec(4'd1,  0, 16'h8000, 16'h0001, 16'h0000, 16'h00AA, 0, 2'd0, 16'h7FFF, 4'b0011, 0, 16'h00AA, 0);
    add_vec(4'd2,  0, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h00AA, 0, 2'd0, 16'h3030, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd3,  0, 16'h0F00, 16'h00F0, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0FF0, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd4,  0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0000, 4'b0100, 0, 16'h00AA, 0);
    add_vec(4'd5,  0, 16'hFF00, 16'h0F0F, 16'h0000, 16'h00AA, 0, 2'd0, 16'hF000, 4'b1000, 0, 16'h00AA, 0);
    add_vec(4'd6,  0, 16'h0001, 16'h0004, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0010, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd7,  0, 16'h8000, 16'h000F, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0001, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd8,  0, 16'h8000, 16'h0004, 16'h0000, 16'h00AA, 0, 2'd0, 16'hF800, 4'b1000, 0, 16'h00AA, 0);
    add_vec(4'd9,  0, 16'h8001, 16'h0011, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0003, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd10, 1, 16'h5555, 16'h0000, 16'h1234, 16'h00AA, 0, 2'd0, 16'h1234, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd11, 1, 16'h0012, 16'h0000, 16'hFF34, 16'h00AA, 0, 2'd0, 16'h1234, 4'b0000, 0, 16'h00AA, 0);
    add_vec(4'd14, 0, 16'h0001, 16'h0001, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0000, 4'b0100, 0, 16'h00AA, 1);
    add_vec(4'd15, 0, 16'h0001, 16'h0001, 16'h0000, 16'h00AA, 0, 2'd0, 16'h0000, 4'b0100, 0, 16'h00AA, 1);
    add_vec(4'd13, 0, 16'h0064, 16'h0000, 16'h0000, 16'h00AA, 0, 2'd0, 16'hFFFF, 4'b1000, 0, 16'h00AA, 1);
    // Branches: op and src_imm must be ignored.
    add_vec(4'd12, 1, 16'h0003, 16'h0000, 16'hFFF8, 16'h0010, 1, 2'd1, 16'h0010, 4'b0000, 1, 16'h0008, 0);
    add_vec(4'd13, 0, 16'h0003, 16'h0000, 16'hFFF8, 16'h0010, 1, 2'd0, 16'h0010, 4'b0000, 0, 16'h0010, 0);
    add_vec(4'd0,  0, 16'h8000, 16'h0000, 16'h0010, 16'h0100, 1, 2'd2, 16'h0100, 4'b1000, 1, 16'h0110, 0);
    add_vec(4'd0,  0, 16'h8000, 16'h0000, 16'h0010, 16'h0100, 1, 2'd3, 16'h0100, 4'b1000, 0, 16'h0100, 0);
    add_vec(4'd0,  0, 16'h0000, 16'h0000, 16'h0004, 16'hFFFE, 1, 2'd0, 16'hFFFE, 4'b0100, 1, 16'h0002, 0);

    // Reset held with in_valid high.
    repeat (3) @(negedge clk);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst result", {16'd0, result}, 32'd0);
    chk("rst flags", {28'd0, flags}, 32'd0);
    chk("rst br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst pc_target", {16'd0, pc_target}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);

    foreach (vq[i]) begin
      op = vq[i].op; src_imm = vq[i].src_imm; rd1 = vq[i].rd1; rd2 = vq[i].rd2;
      imm = vq[i].imm; pc_next = vq[i].pc_next; br_en = vq[i].br_en;
      br_type = vq[i].br_type; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d result", i), {16'd0, result}, {16'd0, vq[i].e_res});
      chk($sformatf("v%0d flags", i), {28'd0, flags}, {28'd0, vq[i].e_flags});
      chk($sformatf("v%0d br_taken", i), {31'd0, br_taken}, {31'd0, vq[i].e_tk});
      chk($sformatf("v%0d pc_target", i), {16'd0, pc_target}, {16'd0, vq[i].e_pct});
      chk($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vq[i].e_err});
    end
    @(negedge clk);

    // MUL and DIVU, 16-bit; the disabled-unit instance answers in one cycle with err.
    drive_op(4'd12, 16'h0012, 16'h0034);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("dis mul out_valid", {31'd0, d_out_valid}, 32'd1);
    chk("dis mul result", {16'd0, d_result}, 32'd0);
    chk("dis mul err", {31'd0, d_err}, 32'd1);
    wait_out(1'b0, 17, "mul16");
    chk("mul16 result", {16'd0, result}, 32'h0000_03A8);
    chk("mul16 err", {31'd0, err}, 32'd0);
    @(negedge clk);
    drive_op(4'd13, 16'd100, 16'd7);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("dis divu err", {31'd0, d_err}, 32'd1);
    wait_out(1'b0, 17, "divu16");
    chk("divu16 result", {16'd0, result}, 32'd14);
    chk("divu16 flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    drive_op(4'd13, 16'hFFFF, 16'h0003);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_out(1'b0, 17, "divu big");
    chk("divu big result", {16'd0, result}, 32'h0000_5555);
    @(negedge clk);

    // Backpressure across two ADDs.
    out_ready = 1'b0;
    drive_op(4'd0, 16'd1, 16'd2);
    @(posedge clk); @(negedge clk);
    drive_op(4'd0, 16'd4, 16'd5);
    chk("bp first result", {16'd0, result}, 32'd3);
    chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("bp hold result", {16'd0, result}, 32'd3);
    chk("bp hold valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready on consume", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp second result", {16'd0, result}, 32'd9);
    chk("bp second valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp drained", {31'd0, out_valid}, 32'd0);

    // MUL completing while downstream is stalled.
    out_ready = 1'b0;
    drive_op(4'd12, 16'd3, 16'd5);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_out(1'b0, 17, "mul stalled");
    repeat (3) @(negedge clk);
    chk("mul stalled hold", {16'd0, result}, 32'd15);
    chk("mul stalled valid", {31'd0, out_valid}, 32'd1);
    chk("mul stalled in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mul stalled consumed", {31'd0, out_valid}, 32'd0);

    // Flush during a DIVU, then flush against a simultaneous accept.
    drive_op(4'd13, 16'h1234, 16'd3);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    watch_idle(25, "flush divu");
    drive_op(4'd0, 16'd1, 16'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush beats accept", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a MUL.
    drive_op(4'd12, 16'h0012, 16'h0034);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid rst recovered", {31'd0, in_ready}, 32'd1);
    watch_idle(25, "mid rst");

    // 32-bit instance: MUL latency is WIDTH+1.
    op = 4'd12; rd1_32 = 32'h0000_0012; rd2_32 = 32'h0000_0034; in_valid32 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid32 = 1'b0;
    wait_out(1'b1, 33, "mul32");
    chk("mul32 result", w_result, 32'h0000_03A8);
    chk("mul32 err", {31'd0, w_err}, 32'd0);
    @(negedge clk);
    op = 4'd12; rd1_32 = 32'h0001_2345; rd2_32 = 32'h0000_0100; in_valid32 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid32 = 1'b0;
    wait_out(1'b1, 33, "mul32 big");
    chk("mul32 big result", w_result, 32'h0123_4500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
